// File: rtl/pwm_gen.sv
// pwm_gen: duty-programmable PWM generator driven by an external divided clock.
//
// Counts rising edges of tick_in (the clock-divider output) into a PWM period
// of PERIOD ticks. Duty values are written over a valid/ready handshake into a
// shadow register. They only take effect at a period boundary or at start-up,
// so the output never glitches.
//
// Build option: define PWM_GEN_SYNC_EN to pass tick_in through a 2-flop
// synchronizer and a delay flop before edge detection. Use it whenever tick_in
// is not synchronous to clk. Without it, tick_in is edge-detected directly.
//
// Ports:
//   clk          system clock (50 MHz)
//   rst          asynchronous reset, active low
//   tick_in      divided clock, time base of the PWM
//   en           run request, sampled at start and at each period wrap
//   duty_in      requested duty in ticks (WIDTH bits)
//   duty_valid   duty_in valid
//   duty_ready   shadow register empty, a duty value can be accepted
//   pwm_out      registered PWM output
//   period_done  one-cycle pulse after each period wrap
//   busy         FSM not idle
`timescale 1ns/1ps

module pwm_gen #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PERIOD = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             en,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             period_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_active;
  logic [WIDTH-1:0] shadow;
  logic             shadow_full;
  logic             tick;
  logic             start;
  logic             wrap;
  logic             load;
  logic             xfer;

`ifdef PWM_GEN_SYNC_EN
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;
`else
  logic tick_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_d <= 1'b0;
    end else begin
      tick_d <= tick_in;
    end
  end

  assign tick = tick_in & ~tick_d;
`endif

  // ready is simply "shadow empty", so a transfer can never overwrite a
  // pending value; at a coinciding wrap the old shadow still reaches
  // duty_active because both updates are non-blocking.
  assign duty_ready = ~shadow_full;
  assign busy       = (state != IDLE);
  assign xfer       = duty_valid && !shadow_full;
  assign start      = (state == IDLE) && tick && en;
  assign wrap       = (state == RUN) && tick && (cnt == LAST);
  assign load       = start || wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      duty_active <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
    end else begin
      period_done <= wrap;
      // cnt never exceeds PERIOD-1, so any duty >= PERIOD holds the output high
      pwm_out     <= (state == RUN) && (cnt < duty_active);

      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (tick) begin
            if (cnt == LAST) begin
              cnt <= '0;
              if (!en) begin
                state <= DRAIN;
              end
            end else begin
              cnt <= cnt + WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase

      if (load && shadow_full) begin
        duty_active <= shadow;
      end

      if (xfer) begin
        shadow      <= duty_in;
        shadow_full <= 1'b1;
      end else if (load) begin
        shadow_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed bench for pwm_gen with PERIOD=10, WIDTH=8.
// Expected values are hand-derived per tick; LAT is the tick_in-rise to
// cnt-update latency of the selected build.
`timescale 1ns/1ps

module tb_pwm_gen;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned PERIOD = 10;
`ifdef PWM_GEN_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 1;
`endif
  localparam int unsigned SH = 250;  // slow tick half period (100 kHz)
  localparam int unsigned FH = 10;   // fast tick half period

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick_in = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] duty_in = '0;
  logic             duty_valid = 1'b0;
  logic             duty_ready;
  logic             pwm_out;
  logic             period_done;
  logic             busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned high_cnt = 0;
  int unsigned pd_cnt = 0;
  int unsigned hi0;
  int unsigned pd0;

  pwm_gen #(.WIDTH(WIDTH), .PERIOD(PERIOD)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .tick_in    (tick_in),
    .en         (en),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm_out    (pwm_out),
    .period_done(period_done),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  // Cycle counters: value held during each clock cycle, sampled at its end.
  always @(posedge clk) begin
    if (pwm_out) high_cnt <= high_cnt + 1;
    if (period_done) pd_cnt <= pd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // All tick tasks start and end just after a falling clock edge.
  task automatic tick(input int unsigned hi, input int unsigned lo);
    tick_in = 1'b1;
    repeat (hi) @(negedge clk);
    tick_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic run_ticks(input int unsigned n, input logic [9:0] pat,
                           input int unsigned hi, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      tick(hi, hi);
      chk($sformatf("%s_pwm%0d", tag, i), pwm_out, pat[i]);
    end
  endtask

  task automatic write_duty(input logic [WIDTH-1:0] v, input string tag);
    logic got;
    got = 1'b0;
    duty_in    = v;
    duty_valid = 1'b1;
    for (int unsigned i = 0; i < 50; i++) begin
      if (duty_ready) begin
        got = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    duty_valid = 1'b0;
    chk({tag, "_accepted"}, got, 1);
  endtask

  // Wrap tick with a full shadow: checks ready/period_done edge by edge.
  task automatic wrap_tick_chk(input logic exp_pwm, input string tag);
    tick_in = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    chk({tag, "_ready_pre"}, duty_ready, 0);
    chk({tag, "_pd_pre"}, period_done, 0);
    @(negedge clk);
    chk({tag, "_ready_post"}, duty_ready, 1);
    chk({tag, "_pd"}, period_done, 1);
    @(negedge clk);
    chk({tag, "_pd_end"}, period_done, 0);
    chk({tag, "_pwm"}, pwm_out, exp_pwm);
    repeat (FH - LAT - 1) @(negedge clk);
    tick_in = 1'b0;
    repeat (FH) @(negedge clk);
  endtask

  // IDLE->RUN tick: checks start latency and first pwm_out update.
  task automatic start_tick_chk(input string tag);
    tick_in = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    chk({tag, "_busy_pre"}, busy, 0);
    @(negedge clk);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_pwm_pre"}, pwm_out, 0);
    @(negedge clk);
    chk({tag, "_pwm"}, pwm_out, 1);
    repeat (FH - LAT - 1) @(negedge clk);
    tick_in = 1'b0;
    repeat (FH) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_pd", period_done, 0);
    chk("rst_ready", duty_ready, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Duty 3 at 100 kHz ticks: 1500 high cycles per 5000-cycle period
    write_duty(8'd3, "d3");
    chk("d3_ready_low", duty_ready, 0);
    en = 1'b1;
    tick(SH, SH);
    chk("p1_busy", busy, 1);
    chk("p1_ready", duty_ready, 1);
    chk("p1_pwm0", pwm_out, 1);
    run_ticks(9, 10'b0000000011, SH, "p1");
    hi0 = high_cnt;
    pd0 = pd_cnt;
    run_ticks(10, 10'b0000000111, SH, "p2");
    chk("p2_high_cycles", high_cnt - hi0, 1500);
    chk("p2_pd_count", pd_cnt - pd0, 1);

    // Duty 0 then 12: constant low, then saturated high
    write_duty(8'd0, "d0");
    hi0 = high_cnt;
    pd0 = pd_cnt;
    run_ticks(10, 10'b0000000000, FH, "p3");
    chk("p3_high_cycles", high_cnt - hi0, 0);
    chk("p3_pd_count", pd_cnt - pd0, 1);
    write_duty(8'd12, "d12");
    run_ticks(10, 10'b1111111111, FH, "p4");
    hi0 = high_cnt;
    pd0 = pd_cnt;
    run_ticks(10, 10'b1111111111, FH, "p5");
    chk("p5_high_cycles", high_cnt - hi0, 20 * FH);
    chk("p5_pd_count", pd_cnt - pd0, 1);

    // Duty 7 written mid-period while 3 is active
    write_duty(8'd3, "d3b");
    run_ticks(5, 10'b0000000111, FH, "p6a");
    write_duty(8'd7, "d7");
    chk("d7_ready_low", duty_ready, 0);
    run_ticks(5, 10'b0000000000, FH, "p6b");
    chk("p6_ready_held", duty_ready, 0);
    wrap_tick_chk(1'b1, "w7");
    run_ticks(9, 10'b0000111111, FH, "p7");

    // Second write while shadow full waits for the wrap
    write_duty(8'd5, "d5");
    duty_in    = 8'd9;
    duty_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("d9_blocked", duty_ready, 0);
    wrap_tick_chk(1'b1, "w5");
    chk("d9_taken", duty_ready, 0);
    duty_valid = 1'b0;
    run_ticks(9, 10'b0000001111, FH, "p8");

    // en dropped at tick 4: period completes, then DRAIN and IDLE
    wrap_tick_chk(1'b1, "w9");
    run_ticks(3, 10'b0000000111, FH, "p9a");
    en = 1'b0;
    run_ticks(6, 10'b0000011111, FH, "p9b");
    chk("p9_busy", busy, 1);
    tick_in = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("drain_pd", period_done, 1);
    chk("drain_busy", busy, 1);
    chk("drain_pwm", pwm_out, 0);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_pwm", pwm_out, 0);
    repeat (FH - LAT - 1) @(negedge clk);
    tick_in = 1'b0;
    repeat (FH) @(negedge clk);
    pd0 = pd_cnt;
    run_ticks(2, 10'b0000000000, FH, "idle");
    chk("idle_busy_hold", busy, 0);
    chk("idle_no_pd", pd_cnt - pd0, 0);

    // Restart, then reset at tick 5
    en = 1'b1;
    start_tick_chk("s1");
    run_ticks(5, 10'b0000011111, FH, "p10");
    write_duty(8'd2, "d2");
    chk("d2_ready_low", duty_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_pwm", pwm_out, 0);
    chk("arst_ready", duty_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_pd", period_done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    write_duty(8'd4, "d4");
    start_tick_chk("s2");
    chk("s2_ready", duty_ready, 1);
    run_ticks(9, 10'b0000000111, FH, "p11");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
